// File: rtl/imem_fetch_ctrl.sv
// rtl/imem_fetch_ctrl.sv - instruction fetch controller with prefetch FIFO
// Drives a combinational imem, queues {pc, instr} pairs and hands them to decode.
module imem_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        halt,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic [31:0] fetch_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_STALL  = 2'd1;
  localparam logic [1:0] ST_HALTED = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   fetch_cnt_q, fetch_cnt_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic [31:0]   pc_mem_q [DEPTH];
  logic [31:0]   pc_mem_d [DEPTH];
  logic [31:0]   instr_mem_q [DEPTH];
  logic [31:0]   instr_mem_d [DEPTH];

  logic empty, full, pop, push;
  logic redirect_lsb_unused;

  assign redirect_lsb_unused = ^redirect_pc[1:0];

  assign empty     = (count_q == '0);
  assign full      = (count_q == FULL_CNT);
  assign pop       = !empty && out_ready;
  assign push      = (state_q == ST_RUN) && !redirect_valid && (!full || pop);

  assign imem_addr = fetch_pc_q;
  assign out_valid = !empty;
  assign out_pc    = empty ? 32'h0 : pc_mem_q[rd_ptr_q];
  assign out_instr = empty ? 32'h0 : instr_mem_q[rd_ptr_q];
  assign fetch_cnt = fetch_cnt_q;

  always_comb begin
    fetch_pc_d  = fetch_pc_q;
    fetch_cnt_d = fetch_cnt_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    pc_mem_d    = pc_mem_q;
    instr_mem_d = instr_mem_q;

    // A redirect wins over everything: flush, drop any pop, restart at the target.
    if (redirect_valid) begin
      fetch_pc_d = {redirect_pc[31:2], 2'b00};
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
    end else begin
      if (push) begin
        pc_mem_d[wr_ptr_q]    = fetch_pc_q;
        instr_mem_d[wr_ptr_q] = imem_instr;
        wr_ptr_d              = wr_ptr_q + PW'(1);
        fetch_pc_d            = fetch_pc_q + 32'd4;
        fetch_cnt_d           = fetch_cnt_q + 32'd1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + (PW+1)'(1);
        2'b01:   count_d = count_q - (PW+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN: begin
        if (halt)                                  state_d = ST_HALTED;
        else if (full && !pop && !redirect_valid)  state_d = ST_STALL;
      end
      ST_STALL: begin
        if (halt)                                        state_d = ST_HALTED;
        else if (redirect_valid || (count_q < FULL_CNT)) state_d = ST_RUN;
      end
      ST_HALTED: begin
        // A redirect while halted only moves the PC; release needs a quiet cycle.
        if (!halt && !redirect_valid) state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RUN;
      fetch_pc_q  <= RESET_PC;
      fetch_cnt_q <= 32'h0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      fetch_cnt_q <= fetch_cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    pc_mem_q    <= pc_mem_d;
    instr_mem_q <= instr_mem_d;
  end

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// tb/tb_imem_fetch_ctrl.sv - directed self-checking bench for imem_fetch_ctrl
// Models the team imem combinationally and walks reset, stall, redirect, halt, wrap and reset cases.
module tb_imem_fetch_ctrl;

  logic        clk;
  logic        rst;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        halt;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [31:0] fetch_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  imem_fetch_ctrl #(.RESET_PC(32'h0), .DEPTH(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .halt           (halt),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .fetch_cnt      (fetch_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Team imem: addi xN,x0,N in the low words, two fixed words at 0x50/0x54, a tagged filler elsewhere.
  function automatic logic [31:0] imem_model(input logic [31:0] a);
    logic [31:0] n;
    if (a == 32'h50) return 32'h0004_1103;
    if (a == 32'h54) return 32'h0004_9263;
    if (a < 32'h40) begin
      n = {27'h0, a[6:2]};
      return (n << 20) | (n << 7) | 32'h13;
    end
    return {16'hC0DE, a[15:0]};
  endfunction

  always_comb imem_instr = imem_model(imem_addr);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for a valid head, checks it, then lets the handshake happen.
  task automatic pop_expect(input string tag, input logic [31:0] epc, input logic [31:0] ei);
    int n;
    n = 0;
    while (!out_valid && n < 8) begin
      step();
      n++;
    end
    chk({tag, "_valid"}, {31'h0, out_valid}, 32'h1);
    chk({tag, "_pc"}, out_pc, epc);
    chk({tag, "_instr"}, out_instr, ei);
    step();
  endtask

  initial begin
    rst            = 1'b1;
    halt           = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    out_ready      = 1'b1;
    step();
    step();

    chk("rst_valid", {31'h0, out_valid}, 32'h0);
    chk("rst_pc", out_pc, 32'h0);
    chk("rst_instr", out_instr, 32'h0);
    chk("rst_cnt", fetch_cnt, 32'h0);
    chk("rst_addr", imem_addr, 32'h0);

    // Streaming from reset release with decode always ready.
    rst = 1'b0;
    step();
    chk("c1_valid", {31'h0, out_valid}, 32'h1);
    chk("c1_pc", out_pc, 32'h0);
    chk("c1_instr", out_instr, 32'h0000_0013);
    chk("c1_cnt", fetch_cnt, 32'd1);
    step();
    chk("c2_pc", out_pc, 32'h4);
    chk("c2_instr", out_instr, 32'h0010_0093);
    chk("c2_cnt", fetch_cnt, 32'd2);
    step();
    chk("c3_pc", out_pc, 32'h8);
    chk("c3_instr", out_instr, 32'h0020_0113);
    chk("c3_cnt", fetch_cnt, 32'd3);

    // Backpressure from reset: fill, stall, then drain in order.
    rst = 1'b1;
    out_ready = 1'b0;
    step();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) step();
    chk("bp_state", {30'h0, dut.state_q}, 32'd1);
    chk("bp_addr", imem_addr, 32'h8);
    chk("bp_head_pc", out_pc, 32'h0);
    chk("bp_head_instr", out_instr, 32'h0000_0013);
    chk("bp_cnt", fetch_cnt, 32'd2);
    out_ready = 1'b1;
    pop_expect("bp0", 32'h0, 32'h0000_0013);
    pop_expect("bp1", 32'h4, 32'h0010_0093);
    pop_expect("bp2", 32'h8, 32'h0020_0113);

    // Redirect with the FIFO full and a same-cycle pop.
    rst = 1'b1;
    out_ready = 1'b0;
    step();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) step();
    out_ready      = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h53;
    step();
    redirect_valid = 1'b0;
    chk("rd_valid", {31'h0, out_valid}, 32'h0);
    chk("rd_addr", imem_addr, 32'h50);
    chk("rd_cnt", fetch_cnt, 32'd2);
    step();
    chk("rd0_pc", out_pc, 32'h50);
    chk("rd0_instr", out_instr, 32'h0004_1103);
    step();
    chk("rd1_pc", out_pc, 32'h54);
    chk("rd1_instr", out_instr, 32'h0004_9263);
    chk("rd1_cnt", fetch_cnt, 32'd4);

    // Halt for four cycles: drain, freeze, then resume without skipping.
    halt = 1'b1;
    step();
    chk("h1_addr", imem_addr, 32'h5C);
    chk("h1_cnt", fetch_cnt, 32'd5);
    for (int i = 0; i < 3; i++) step();
    chk("h4_addr", imem_addr, 32'h5C);
    chk("h4_cnt", fetch_cnt, 32'd5);
    chk("h4_valid", {31'h0, out_valid}, 32'h0);
    chk("h4_state", {30'h0, dut.state_q}, 32'd2);
    halt = 1'b0;
    pop_expect("resume", 32'h5C, 32'hC0DE_005C);

    // Halt and redirect together: redirect lands, controller parks in HALTED.
    halt           = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    step();
    redirect_valid = 1'b0;
    chk("hr_state", {30'h0, dut.state_q}, 32'd2);
    chk("hr_addr", imem_addr, 32'h100);
    chk("hr_valid", {31'h0, out_valid}, 32'h0);
    step();
    chk("hr_hold_addr", imem_addr, 32'h100);
    halt = 1'b0;
    pop_expect("hr", 32'h100, 32'hC0DE_0100);

    // PC wraps modulo 2^32.
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFF8;
    step();
    redirect_valid = 1'b0;
    pop_expect("wr0", 32'hFFFF_FFF8, 32'hC0DE_FFF8);
    pop_expect("wr1", 32'hFFFF_FFFC, 32'hC0DE_FFFC);
    pop_expect("wr2", 32'h0000_0000, 32'h0000_0013);

    // Reset while full discards everything.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) step();
    chk("mr_full", {29'h0, dut.count_q}, 32'd2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mr_valid", {31'h0, out_valid}, 32'h0);
    chk("mr_state", {30'h0, dut.state_q}, 32'd0);
    chk("mr_cnt", fetch_cnt, 32'h0);
    chk("mr_addr", imem_addr, 32'h0);
    out_ready = 1'b1;
    pop_expect("mr0", 32'h0, 32'h0000_0013);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
